// File: rtl/regfile_pkg.sv
// Shared constants for the parametrised register file: dump FSM encoding and default geometry.
package regfile_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } dump_state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 32;

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Dump sequencer: walks indices 0..DEPTH-1 over a valid/ready handshake, then pulses done.
module regfile_dump_ctrl
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dump_start,
    input  logic          dump_ready,
    output logic [AW-1:0] dump_idx,
    output logic          dump_valid,
    output logic          dump_busy,
    output logic          dump_done
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    dump_state_t   state_reg;
    logic [AW-1:0] idx_reg;
    logic          valid_reg;
    logic          busy_reg;
    logic          done_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (dump_start) begin
                        state_reg <= SCAN;
                        idx_reg   <= '0;
                        valid_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                    end
                end
                SCAN: begin
                    // dump_start is deliberately not looked at here: no restart mid-scan
                    if (dump_ready) begin
                        if (idx_reg == LAST_IDX) begin
                            state_reg <= DONE;
                            valid_reg <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    idx_reg   <= '0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    idx_reg   <= '0;
                    valid_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign dump_idx   = idx_reg;
    assign dump_valid = valid_reg;
    assign dump_busy  = busy_reg;
    assign dump_done  = done_reg;

endmodule

// File: rtl/regfile_dump_param.sv
// Parametrised register file (1 write, NUM_RD combinational reads) with serial dump engine.
// Optional macro REGFILE_WRITE_BYPASS_EN forwards same-cycle write data to reads and dump_data.
module regfile_dump_param
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [AW-1:0]           waddr,
    input  logic [WIDTH-1:0]        wdata,
    input  logic [NUM_RD*AW-1:0]    raddr,
    output logic [NUM_RD*WIDTH-1:0] rdata,
    input  logic                    dump_start,
    output logic                    dump_valid,
    input  logic                    dump_ready,
    output logic [AW-1:0]           dump_idx,
    output logic [WIDTH-1:0]        dump_data,
    output logic                    dump_busy,
    output logic                    dump_done
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic             wr_ok;

    // Entry 0 never takes a write when hardwired, so it keeps its reset value of zero.
    assign wr_ok = we && !((ZERO_REG != 0) && (waddr == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (wr_ok) begin
            mem_reg[waddr] <= wdata;
        end
    end

    function automatic logic [WIDTH-1:0] read_entry(input logic [AW-1:0] addr);
        logic [WIDTH-1:0] val;
        val = mem_reg[addr];
`ifdef REGFILE_WRITE_BYPASS_EN
        if (wr_ok && (addr == waddr)) begin
            val = wdata;
        end
`endif
        return val;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            assign rdata[gi*WIDTH +: WIDTH] = read_entry(raddr[gi*AW +: AW]);
        end
    endgenerate

    assign dump_data = read_entry(dump_idx);

    regfile_dump_ctrl #(
        .DEPTH (DEPTH)
    ) u_dump_ctrl (
        .clk        (clk),
        .rst        (rst),
        .dump_start (dump_start),
        .dump_ready (dump_ready),
        .dump_idx   (dump_idx),
        .dump_valid (dump_valid),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done)
    );

endmodule

// File: tb/tb_regfile_dump_param.sv
// Directed bench for regfile_dump_param: table-driven read/write vectors plus dump scan sequences.
module tb_regfile_dump_param;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 32;
    localparam int NUM_RD = 2;
    localparam int AW     = 5;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    we;
    logic [AW-1:0]           waddr;
    logic [WIDTH-1:0]        wdata;
    logic [NUM_RD*AW-1:0]    raddr;
    logic [NUM_RD*WIDTH-1:0] rdata;
    logic                    dump_start;
    logic                    dump_valid;
    logic                    dump_ready;
    logic [AW-1:0]           dump_idx;
    logic [WIDTH-1:0]        dump_data;
    logic                    dump_busy;
    logic                    dump_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_dump_param #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .raddr      (raddr),
        .rdata      (rdata),
        .dump_start (dump_start),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done)
    );

    typedef struct {
        logic             we;
        logic [AW-1:0]    waddr;
        logic [WIDTH-1:0] wdata;
        logic [AW-1:0]    ra0;
        logic [AW-1:0]    ra1;
        logic [WIDTH-1:0] exp0;
        logic [WIDTH-1:0] exp1;
    } vec_t;

    vec_t             vecs [8];
    logic [WIDTH-1:0] exp_mem [DEPTH];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One scan; optional stall at stall_at and optional mid-scan writes / ignored restart.
    task automatic run_scan(input int stall_at, input int stall_n, input bit with_writes);
        int n;
        int cyc;
        int stall_left;
        logic [WIDTH-1:0] beat_exp [DEPTH];
        n = 0;
        stall_left = stall_n;
        for (int i = 0; i < DEPTH; i++) beat_exp[i] = exp_mem[i];
        if (with_writes) begin
`ifdef REGFILE_WRITE_BYPASS_EN
            beat_exp[10] = 32'h55;
`endif
            beat_exp[20] = 32'h66;
        end
        @(negedge clk);
        dump_start = 1'b1;
        dump_ready = 1'b1;
        @(negedge clk);
        cyc = 1;
        while (n < DEPTH && cyc < 200) begin
            we = 1'b0;
            dump_start = 1'b0;
            dump_ready = 1'b1;
            if (n == stall_at && stall_left > 0) begin
                dump_ready = 1'b0;
                stall_left--;
            end
            if (with_writes && dump_ready) begin
                if (n == 10) begin we = 1'b1; waddr = 5'd10; wdata = 32'h55; end
                if (n == 11) begin we = 1'b1; waddr = 5'd20; wdata = 32'h66; end
                if (n == 15) dump_start = 1'b1;
            end
            #1;
            chk("beat_valid", dump_valid, 1);
            chk("beat_busy", dump_busy, 1);
            chk("beat_done_low", dump_done, 0);
            chk("beat_idx", dump_idx, n);
            chk("beat_data", dump_data, beat_exp[n]);
            @(negedge clk);
            cyc++;
            if (dump_ready) n++;
        end
        if (n < DEPTH) chk("scan_complete", n, DEPTH);
        we = 1'b0;
        dump_start = 1'b0;
        dump_ready = 1'b1;
        #1;
        chk("done_pulse", dump_done, 1);
        chk("done_cycle", cyc, DEPTH + 1 + stall_n);
        chk("done_valid_low", dump_valid, 0);
        chk("done_busy", dump_busy, 1);
        @(negedge clk);
        chk("done_one_cycle", dump_done, 0);
        chk("idle_busy", dump_busy, 0);
        chk("idle_idx", dump_idx, 0);
        chk("idle_valid", dump_valid, 0);
        $display("scan stall_at=%0d stall_n=%0d writes=%0d done at cycle %0d", stall_at, stall_n, with_writes, cyc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] e0;
        logic [WIDTH-1:0] e1;
        int guard;
        bit saw_done;

        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'h0,        32'h0};
        vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 5'd0,  32'h7,        5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
        vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
        vecs[4] = '{1'b1, 5'd31, 32'h12345678, 5'd31, 5'd1,  32'h0,        32'h0};
        vecs[5] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd5,  32'h12345678, 32'hDEADBEEF};
        vecs[6] = '{1'b1, 5'd5,  32'hCAFEF00D, 5'd5,  5'd31, 32'hDEADBEEF, 32'h12345678};
        vecs[7] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  32'hCAFEF00D, 32'h0};

        rst = 1'b0;
        we = 1'b0;
        waddr = '0;
        wdata = '0;
        raddr = '0;
        dump_start = 1'b0;
        dump_ready = 1'b1;

        // Reset asserted away from the clock edge
        #12 rst = 1'b1;
        #10 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", dump_valid, 0);
        chk("rst_idx", dump_idx, 0);
        chk("rst_busy", dump_busy, 0);
        chk("rst_done", dump_done, 0);
        chk("rst_dump_data", dump_data, 0);
        for (int a = 0; a < DEPTH; a++) begin
            raddr = {5'(a), 5'(DEPTH - 1 - a)};
            #1;
            chk("rst_rdata0", rdata[WIDTH-1:0], 0);
            chk("rst_rdata1", rdata[2*WIDTH-1:WIDTH], 0);
        end

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            we = vecs[i].we;
            waddr = vecs[i].waddr;
            wdata = vecs[i].wdata;
            raddr = {vecs[i].ra1, vecs[i].ra0};
            e0 = vecs[i].exp0;
            e1 = vecs[i].exp1;
`ifdef REGFILE_WRITE_BYPASS_EN
            if (vecs[i].we && vecs[i].waddr != 0 && vecs[i].ra0 == vecs[i].waddr) e0 = vecs[i].wdata;
            if (vecs[i].we && vecs[i].waddr != 0 && vecs[i].ra1 == vecs[i].waddr) e1 = vecs[i].wdata;
`endif
            #1;
            chk("vec_rdata0", rdata[WIDTH-1:0], e0);
            chk("vec_rdata1", rdata[2*WIDTH-1:WIDTH], e1);
            $display("vec %0d we=%0d waddr=%0d wdata=%h ra0=%0d ra1=%0d rd0=%h rd1=%h",
                     i, we, waddr, wdata, vecs[i].ra0, vecs[i].ra1, rdata[WIDTH-1:0], rdata[2*WIDTH-1:WIDTH]);
        end
        @(negedge clk);
        we = 1'b0;

        // Preload entry i = i*3; the write to entry 0 is dropped
        for (int i = 0; i < DEPTH; i++) begin
            we = 1'b1;
            waddr = 5'(i);
            wdata = 32'(i * 3);
            exp_mem[i] = 32'(i * 3);
            @(negedge clk);
        end
        we = 1'b0;

        run_scan(-1, 0, 1'b0);
        run_scan(10, 4, 1'b0);
        run_scan(-1, 0, 1'b1);

        exp_mem[10] = 32'h55;
        exp_mem[20] = 32'h66;
        @(negedge clk);
        raddr = {5'd20, 5'd10};
        #1;
        chk("post_scan_rd10", rdata[WIDTH-1:0], exp_mem[10]);
        chk("post_scan_rd20", rdata[2*WIDTH-1:WIDTH], exp_mem[20]);

        // Reset in the middle of a scan
        @(negedge clk);
        dump_start = 1'b1;
        dump_ready = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
        guard = 0;
        while (dump_idx != 5'd12 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("reach_idx12", dump_idx, 12);
        #1 rst = 1'b1;
        #1;
        chk("midrst_valid", dump_valid, 0);
        chk("midrst_busy", dump_busy, 0);
        chk("midrst_idx", dump_idx, 0);
        raddr = {5'd20, 5'd9};
        #1;
        chk("midrst_rd9", rdata[WIDTH-1:0], 0);
        chk("midrst_rd20", rdata[2*WIDTH-1:WIDTH], 0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (dump_done) saw_done = 1'b1;
        end
        chk("midrst_no_done", saw_done, 0);
        chk("midrst_idle_valid", dump_valid, 0);
        $display("reset mid-scan at idx 12 handled");

        // Same-cycle write/read at one address
        @(negedge clk);
        we = 1'b1;
        waddr = 5'd3;
        wdata = 32'd9;
        raddr = {5'd0, 5'd3};
        #1;
`ifdef REGFILE_WRITE_BYPASS_EN
        chk("bypass_rdata0", rdata[WIDTH-1:0], 9);
`else
        chk("nobypass_rdata0", rdata[WIDTH-1:0], 0);
`endif
        @(posedge clk);
        #1;
        we = 1'b0;
        #1;
        chk("after_write_rdata0", rdata[WIDTH-1:0], 9);
        $display("same-cycle write/read addr 3 rd0=%h", rdata[WIDTH-1:0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
